sap_control_sequencer: RTL and testbench

Control sequencer for the 8-bit SAP-style CPU. It drives the control lines of the program counter (`cp`, `ep`, `lp`, `clr_n`) and of the other bus devices. It steps a fixed six-T-state machine cycle (fetch T1–T3, execute T4–T6), decodes the 4-bit opcode from the instruction register, and halts on HLT. It is the initiator side of the program counter's control interface and sits at the top of the datapath.

---
 rtl/sap_pkg.sv | 50 +++++
 rtl/sap_step_timer.sv | 34 +++
 rtl/sap_control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-state encoding
// and the packed control word driven onto the datapath.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Encoding is exported unchanged on t_state.
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_T1    = 3'd1,
    ST_T2    = 3'd2,
    ST_T3    = 3'd3,
    ST_T4    = 3'd4,
    ST_T5    = 3'd5,
    ST_T6    = 3'd6,
    ST_HALT  = 3'd7
  } state_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lp;
    logic clr_n;
    logic mar_load;
    logic ir_load;
    logic a_load;
    logic b_load;
    logic out_load;
    logic ram_oe;
    logic ir_oe;
    logic a_oe;
    logic alu_oe;
    logic alu_sub;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{clr_n: 1'b1, default: 1'b0};

  // Sub-cycle counter width; CLEAR always needs to count to 1.
  function automatic int cnt_width(input int steps);
    return (steps > 2) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/sap_step_timer.sv
// Sub-cycle counter: counts 0..limit inside one T-state and flags the first
// and last clock of it.
module sap_step_timer
  import sap_pkg::*;
#(
  parameter int STEP_CYCLES = 2,
  localparam int CW = cnt_width(STEP_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] limit,
  input  logic          restart,
  output logic          step_first,
  output logic          step_last,
  output logic          advance
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || step_last) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign step_first = (count == '0);
  assign step_last  = (count == limit);
  assign advance    = step_last && !restart;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-style CPU control sequencer: six T-states per instruction, opcode
// decode into bus enables and one-clock load/count strobes, HLT support.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       pc_cp,
  output logic       pc_ep,
  output logic       pc_lp,
  output logic       pc_clr_n,
  output logic       mar_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       out_load,
  output logic       ram_oe,
  output logic       ir_oe,
  output logic       a_oe,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       halted,
  output logic [2:0] t_state
);

  localparam int CW = cnt_width(STEP_CYCLES);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] limit;
  logic          restart;
  logic          step_first;
  logic          step_last;
  logic          advance;
  logic          sample;
  logic          halt_req;
  logic [3:0]    op_q;
  logic          zero_q;
  logic [3:0]    op_eff;
  logic          zero_eff;
  ctrl_t         ctrl;

  // CLEAR is two clocks regardless of the T-state length.
  assign limit = (state == ST_CLEAR) ? CW'(1) : CW'(STEP_CYCLES - 1);

  sap_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .limit      (limit),
    .restart    (restart),
    .step_first (step_first),
    .step_last  (step_last),
    .advance    (advance)
  );

  // The IR is loaded at the end of T3, so opcode is used live in the first
  // clock of T4 and from the latch afterwards.
  assign sample   = (state == ST_T4) && step_first;
  assign op_eff   = sample ? opcode : op_q;
  assign zero_eff = sample ? zero_flag : zero_q;
  assign halt_req = sample && (op_eff == OP_HLT);
  assign restart  = halt_req || (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (sample) begin
      op_q   <= opcode;
      zero_q <= zero_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (advance) next_state = ST_T1;
      ST_T1:    if (advance) next_state = ST_T2;
      ST_T2:    if (advance) next_state = ST_T3;
      ST_T3:    if (advance) next_state = ST_T4;
      ST_T4: begin
        if (halt_req) begin
          next_state = ST_HALT;
        end else if (advance) begin
          next_state = ST_T5;
        end
      end
      ST_T5:    if (advance) next_state = ST_T6;
      ST_T6:    if (advance) next_state = ST_T1;
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_CLEAR;
    endcase
  end

  // Enables are held for the whole T-state; strobes only when last is set.
  function automatic ctrl_t decode(input state_t st, input logic [3:0] op,
                                   input logic zero, input logic last);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      ST_CLEAR: c.clr_n = 1'b0;
      ST_T1: begin
        c.ep       = 1'b1;
        c.mar_load = last;
      end
      ST_T2: c.cp = last;
      ST_T3: begin
        c.ram_oe  = 1'b1;
        c.ir_load = last;
      end
      ST_T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            c.ir_oe    = 1'b1;
            c.mar_load = last;
            c.alu_sub  = (op == OP_SUB);
          end
          OP_JMP: begin
            c.ir_oe = 1'b1;
            c.lp    = last;
          end
          OP_JZ: begin
            c.ir_oe = 1'b1;
            c.lp    = last && zero;
          end
          OP_OUT: begin
            c.a_oe     = 1'b1;
            c.out_load = last;
          end
          default: c = CTRL_IDLE;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_LDA: begin
            c.ram_oe = 1'b1;
            c.a_load = last;
          end
          OP_ADD, OP_SUB: begin
            c.ram_oe  = 1'b1;
            c.b_load  = last;
            c.alu_sub = (op == OP_SUB);
          end
          default: c = CTRL_IDLE;
        endcase
      end
      ST_T6: begin
        if (op == OP_ADD || op == OP_SUB) begin
          c.alu_oe  = 1'b1;
          c.a_load  = last;
          c.alu_sub = (op == OP_SUB);
        end
      end
      ST_HALT: c.halted = 1'b1;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  always_comb begin
    ctrl = decode(state, op_eff, zero_eff, step_last);
  end

  assign pc_cp    = ctrl.cp;
  assign pc_ep    = ctrl.ep;
  assign pc_lp    = ctrl.lp;
  assign pc_clr_n = ctrl.clr_n;
  assign mar_load = ctrl.mar_load;
  assign ir_load  = ctrl.ir_load;
  assign a_load   = ctrl.a_load;
  assign b_load   = ctrl.b_load;
  assign out_load = ctrl.out_load;
  assign ram_oe   = ctrl.ram_oe;
  assign ir_oe    = ctrl.ir_oe;
  assign a_oe     = ctrl.a_oe;
  assign alu_oe   = ctrl.alu_oe;
  assign alu_sub  = ctrl.alu_sub;
  assign halted   = ctrl.halted;
  assign t_state  = state;

  // Bus contention guard: never more than one driver on the bus.
  a_bus_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ctrl.ep, ctrl.ram_oe, ctrl.ir_oe, ctrl.a_oe, ctrl.alu_oe}));

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer with STEP_CYCLES = 2.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero_flag;
  logic       pc_cp, pc_ep, pc_lp, pc_clr_n;
  logic       mar_load, ir_load, a_load, b_load, out_load;
  logic       ram_oe, ir_oe, a_oe, alu_oe, alu_sub, halted;
  logic [2:0] t_state;
  logic [14:0] vec;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] CP    = 15'h4000;
  localparam logic [14:0] EP    = 15'h2000;
  localparam logic [14:0] LP    = 15'h1000;
  localparam logic [14:0] CLRN  = 15'h0800;
  localparam logic [14:0] MAR   = 15'h0400;
  localparam logic [14:0] IRL   = 15'h0200;
  localparam logic [14:0] AL    = 15'h0100;
  localparam logic [14:0] BL    = 15'h0080;
  localparam logic [14:0] OUTL  = 15'h0040;
  localparam logic [14:0] RAMOE = 15'h0020;
  localparam logic [14:0] IROE  = 15'h0010;
  localparam logic [14:0] AOE   = 15'h0008;
  localparam logic [14:0] ALUOE = 15'h0004;
  localparam logic [14:0] SUB   = 15'h0002;
  localparam logic [14:0] HALT  = 15'h0001;
  localparam logic [14:0] OE_MASK = EP | RAMOE | IROE | AOE | ALUOE;
  localparam logic [14:0] ST_MASK = CP | LP | MAR | IRL | AL | BL | OUTL;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic [14:0] h4, s4, h5, s5, h6, s6;
  } vec_t;

  vec_t vecs[10];

  sap_control_sequencer #(.STEP_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero_flag (zero_flag),
    .pc_cp     (pc_cp),
    .pc_ep     (pc_ep),
    .pc_lp     (pc_lp),
    .pc_clr_n  (pc_clr_n),
    .mar_load  (mar_load),
    .ir_load   (ir_load),
    .a_load    (a_load),
    .b_load    (b_load),
    .out_load  (out_load),
    .ram_oe    (ram_oe),
    .ir_oe     (ir_oe),
    .a_oe      (a_oe),
    .alu_oe    (alu_oe),
    .alu_sub   (alu_sub),
    .halted    (halted),
    .t_state   (t_state)
  );

  assign vec = {pc_cp, pc_ep, pc_lp, pc_clr_n, mar_load, ir_load, a_load,
                b_load, out_load, ram_oe, ir_oe, a_oe, alu_oe, alu_sub, halted};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] t_exp, input logic [14:0] v_exp);
    checks++;
    if (t_state !== t_exp || vec !== v_exp) begin
      errors++;
      $display("FAIL %s: got t_state=%0d ctrl=%h, want t_state=%0d ctrl=%h",
               name, t_state, vec, t_exp, v_exp);
    end
  endtask

  task automatic release_reset(input string name);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) chk({name, "_clear1"}, 3'd0, 15'h0);
    @(negedge clk) chk({name, "_clear2"}, 3'd0, 15'h0);
  endtask

  // Checks T-states t_lo..t_hi of one instruction, two clocks each.
  task automatic run_states(input string name, input vec_t v, input int t_lo, input int t_hi);
    logic [14:0] hold, strb;
    for (int t = t_lo; t <= t_hi; t++) begin
      case (t)
        1:       begin hold = EP;    strb = MAR;  end
        2:       begin hold = '0;    strb = CP;   end
        3:       begin hold = RAMOE; strb = IRL;  end
        4:       begin hold = v.h4;  strb = v.s4; end
        5:       begin hold = v.h5;  strb = v.s5; end
        default: begin hold = v.h6;  strb = v.s6; end
      endcase
      for (int s = 0; s < 2; s++) begin
        @(negedge clk);
        chk($sformatf("%s_T%0d_c%0d", name, t, s), 3'(t), CLRN | hold | ((s == 1) ? strb : 15'h0));
      end
    end
  endtask

  task automatic run_instr(input string name, input vec_t v);
    opcode    = v.op;
    zero_flag = v.z;
    run_states(name, v, 1, 6);
  endtask

  initial begin
    vec_t nop;
    vec_t sub_v;
    vec_t hlt_v;
    int   instr;
    int   cur_op;
    logic [2:0]  prev_t;
    logic [14:0] prev_vec;

    vecs[0] = '{op: 4'h0, z: 1'b0, h4: IROE, s4: MAR, h5: RAMOE, s5: AL, h6: 15'h0, s6: 15'h0};
    vecs[1] = '{op: 4'h1, z: 1'b0, h4: IROE, s4: MAR, h5: RAMOE, s5: BL, h6: ALUOE, s6: AL};
    vecs[2] = '{op: 4'h2, z: 1'b0, h4: IROE | SUB, s4: MAR, h5: RAMOE | SUB, s5: BL, h6: ALUOE | SUB, s6: AL};
    vecs[3] = '{op: 4'h3, z: 1'b0, h4: IROE, s4: LP, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[4] = '{op: 4'h4, z: 1'b0, h4: IROE, s4: 15'h0, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[5] = '{op: 4'h4, z: 1'b1, h4: IROE, s4: LP, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[6] = '{op: 4'hE, z: 1'b0, h4: AOE, s4: OUTL, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[7] = '{op: 4'h7, z: 1'b0, h4: 15'h0, s4: 15'h0, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[8] = '{op: 4'h5, z: 1'b1, h4: 15'h0, s4: 15'h0, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};
    vecs[9] = '{op: 4'h0, z: 1'b1, h4: IROE, s4: MAR, h5: RAMOE, s5: AL, h6: 15'h0, s6: 15'h0};
    nop   = vecs[7];
    sub_v = vecs[2];
    hlt_v = '{op: 4'hF, z: 1'b0, h4: 15'h0, s4: 15'h0, h5: 15'h0, s5: 15'h0, h6: 15'h0, s6: 15'h0};

    rst       = 1'b1;
    opcode    = 4'h0;
    zero_flag = 1'b0;
    repeat (3) @(negedge clk) chk("reset_hold", 3'd0, 15'h0);
    release_reset("por");

    // Back-to-back instructions from the table; any extra or missing clock
    // shifts every following check.
    for (int i = 0; i < 10; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the b_load clock of SUB's T5.
    opcode = sub_v.op;
    zero_flag = 1'b0;
    run_states("subrst", sub_v, 1, 4);
    @(negedge clk) chk("subrst_T5_c0", 3'd5, CLRN | RAMOE | SUB);
    @(negedge clk) chk("subrst_T5_c1", 3'd5, CLRN | RAMOE | SUB | BL);
    rst = 1'b1;
    #1 chk("subrst_async", 3'd0, 15'h0);
    release_reset("subrst");
    run_instr("after_subrst", nop);

    // HLT: enter HALT after the first T4 clock and stay there.
    opcode = hlt_v.op;
    run_states("hlt", hlt_v, 1, 3);
    @(negedge clk) chk("hlt_T4", 3'd4, CLRN);
    @(negedge clk) chk("hlt_enter", 3'd7, CLRN | HALT);
    opcode = 4'h1;
    repeat (50) @(negedge clk) chk("hlt_hold", 3'd7, CLRN | HALT);
    rst = 1'b1;
    #1 chk("hlt_rst", 3'd0, 15'h0);
    release_reset("rand");

    // Random instruction stream: bus and strobe invariants, NOP behaviour.
    instr    = 0;
    cur_op   = 0;
    prev_t   = 3'd0;
    prev_vec = '0;
    for (int c = 0; c < 1000 * 12 + 40 && instr <= 1000; c++) begin
      @(negedge clk);
      if (t_state == 3'd1 && prev_t != 3'd1) begin
        instr++;
        cur_op    = (instr % 5 == 0) ? 7 : int'($urandom_range(0, 14));
        opcode    = 4'(cur_op);
        zero_flag = 1'($urandom_range(0, 1));
      end
      checks++;
      if ($countones(vec & OE_MASK) > 1) begin
        errors++;
        $display("FAIL rand_onehot: ctrl=%h has more than one bus enable", vec);
      end
      checks++;
      if ((vec & prev_vec & ST_MASK) != 15'h0) begin
        errors++;
        $display("FAIL rand_strobe_width: ctrl=%h prev=%h, want strobes one clock wide", vec, prev_vec);
      end
      checks++;
      if (t_state == 3'd0 || t_state == 3'd7) begin
        errors++;
        $display("FAIL rand_state: got t_state=%0d, want 1..6", t_state);
      end
      if (cur_op == 7 && t_state >= 3'd4 && t_state <= 3'd6) begin
        checks++;
        if (vec !== CLRN) begin
          errors++;
          $display("FAIL rand_nop: got ctrl=%h, want %h", vec, CLRN);
        end
      end
      prev_t   = t_state;
      prev_vec = vec;
    end
    checks++;
    if (instr < 1000) begin
      errors++;
      $display("FAIL rand_timeout: got %0d instructions, want 1000", instr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
